sram_ctrl: RTL and testbench
============================

# sram_ctrl

Request/response front end that sits directly upstream of the single-port `sram` block (`en`/`we`/`addr`/`din`/`dout`) and is its only master. On reset it clears every SRAM word to zero. It then accepts write and read requests over a valid/ready channel, drives the SRAM port, and returns read data over a valid/ready response channel that tolerates backpressure.

## Interface
- `DATA_WIDTH`, 8: SRAM word width.
- `ADDR_WIDTH`, 4: SRAM address width; DEPTH = 2^ADDR_WIDTH.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted this cycle when `req_valid & req_ready`.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_WIDTH: request address.
- `req_wdata` input DATA_WIDTH: write data; ignored for reads.
- `rsp_valid` output 1: read data available.
- `rsp_ready` input 1: consumer takes the response when `rsp_valid & rsp_ready`.
- `rsp_rdata` output DATA_WIDTH: read data; registered.
- `init_done` output 1: high once the clear pass has finished; registered.
- `mem_en` output 1: drives `sram.en`.
- `mem_we` output 1: drives `sram.we`.
- `mem_addr` output ADDR_WIDTH: drives `sram.addr`.
- `mem_din` output DATA_WIDTH: drives `sram.din`.
- `mem_dout` input DATA_WIDTH: from `sram.dout`.

## Operation
- SRAM contract (fixed):
  - A write occurs at the edge where `en=1, we=1`.
  - A read samples `addr` at the edge where `en=1, we=0`; `dout` is valid in the following cycle.
- FSM states are INIT, IDLE, RD and RSP.
- INIT:
  - `mem_en=1`, `mem_we=1`, `mem_addr=init_cnt`, `mem_din=0`, `req_ready=0`.
  - `init_cnt` (ADDR_WIDTH bits) increments each cycle.
  - When `init_cnt == DEPTH-1`, go to IDLE and set `init_done=1`; `init_cnt` wraps to 0.
- IDLE:
  - `req_ready=1`.
  - `mem_en = req_valid`, `mem_we = req_we`, `mem_addr = req_addr`, `mem_din = req_wdata`; these are combinational from the request.
  - An accepted write stays in IDLE and produces no response.
  - An accepted read goes to RD.
  - No request: `mem_en=0`, `mem_we=0`, `mem_addr` and `mem_din` follow the request inputs (don't-care).
- RD:
  - `req_ready=0`, `mem_en=0`.
  - `rsp_rdata <= mem_dout`, `rsp_valid <= 1`; go to RSP.
- RSP:
  - `req_ready=0`, `mem_en=0`; `rsp_valid` and `rsp_rdata` are held stable.
  - On `rsp_ready=1`: `rsp_valid <= 0`, go to IDLE.
- `rsp_rdata` keeps its last value after the handshake.
- `init_done` never falls except on reset.

## Timing
- Reset values, while `rst_n` is low and immediately after it rises:
  - Registers: state=INIT, `init_cnt=0`, `init_done=0`, `rsp_valid=0`, `rsp_rdata=0`.
  - SRAM-side outputs are decoded from INIT: `mem_en=1`, `mem_we=1`, `mem_addr=0`, `mem_din=0`. A repeated zero write to address 0 during reset is harmless.
  - `req_ready=0`.
- Init duration:
  - The first rising edge after `rst_n` rises writes address 0.
  - The clear takes exactly DEPTH cycles.
  - `init_done` and `req_ready` go high in cycle DEPTH after reset release (cycle 16 for the default, counting cycle 0 as the first one).
- Write: accepted in cycle N; SRAM updated at the end of cycle N. Back-to-back writes run at 1 per cycle.
- Read:
  - Accepted in cycle N; state is RD in N+1; `rsp_valid=1` from cycle N+2.
  - With `rsp_ready` held high, the next request is accepted in N+3, so minimum read spacing is 3 cycles.
- Read-after-write: a write in N followed by a read of the same address in N+1 returns the new data.
- Backpressure: `rsp_valid` and `rsp_rdata` are held indefinitely while `rsp_ready=0`.
- Reset mid-operation (any state, including INIT partway or RSP pending):
  - Aborts immediately to the reset values above.
  - The pending response is dropped and the clear pass restarts from address 0.
- `req_*` inputs are ignored whenever `req_ready=0`. The requester must hold `req_valid` and its payload until accepted.

## Test plan
- Post-reset clear: pre-load address 5 with 0xFF through a direct SRAM hierarchy force, then reset. Required: `init_done` rises exactly 16 cycles after release, and reads of 0x0..0xF all return 0x00.
- Write then read: write 0x3=0xA5, then 0x7=0x3C; read 0x3, then 0x7. Required: `rsp_rdata` = 0xA5, then 0x3C, each with `rsp_valid` at acceptance+2 cycles.
- Backpressure: read 0x3 with `rsp_ready=0` for 4 cycles. Required: `rsp_valid=1` and `rsp_rdata=0xA5` stable throughout, `req_ready=0`, `mem_en=0`; after `rsp_ready=1`, `req_ready=1` the next cycle.
- Back-to-back writes to 0x0..0xF with data 0x10+addr, then read all 16. Required: `req_ready=1` every write cycle, no stalls, and each read returns 0x10+addr.
- Reset mid-read: accept a read of 0x7, assert `rst_n=0` in the RD cycle. Required: `rsp_valid` never rises, `init_done=0`, `mem_we=1`, `mem_addr=0`, and 0x7 reads 0x00 after the new clear pass.
- Idle quiet: `req_valid=0` for 10 cycles after init. Required: `mem_en=0` throughout and `rsp_valid=0`.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: sole master of a single-port SRAM. After reset it zero-fills
// every word, then serves write/read requests over a valid/ready channel and
// returns read data on a backpressure-tolerant response channel.
module sram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    // State and datapath registers; reset restarts the clear pass and drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= {ADDR_WIDTH{1'b0}};
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_INIT: begin
                // Counter wraps to zero naturally after the last address.
                init_cnt_d = init_cnt_q + ADDR_ONE;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (req_valid && !req_we) begin
                    state_d = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                // SRAM dout is valid the cycle after the read was issued.
                rsp_rdata_d = mem_dout;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // SRAM port and request-ready decode from the current state.
    always_comb begin
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = req_addr;
        mem_din   = req_wdata;
        case (state_q)
            ST_INIT: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = init_cnt_q;
                mem_din  = {DATA_WIDTH{1'b0}};
            end
            ST_IDLE: begin
                // Request drives the SRAM directly so a write lands in its acceptance cycle.
                req_ready = 1'b1;
                mem_en    = req_valid;
                mem_we    = req_valid & req_we;
            end
            ST_RD: begin
                mem_en = 1'b0;
            end
            ST_RSP: begin
                mem_en = 1'b0;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: behavioural SRAM plus a reference memory array,
// directed steps followed by a randomized write/read mix.
module tb_sram_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    // Back-door preload port of the SRAM model.
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] op_a;
    logic [DW-1:0] op_d;

    always #5 clk = ~clk;

    sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Single-port SRAM model: write at the enabled edge, read data valid next cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram_mem[mem_addr] <= mem_din;
            else        mem_dout <= sram_mem[mem_addr];
        end
        if (pre_en) sram_mem[pre_addr] <= pre_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called with rst_n low: release reset and follow the clear pass cycle by cycle.
    task automatic run_init();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("c0_init_done", {31'd0, init_done}, 32'd0);
        chk("c0_req_ready", {31'd0, req_ready}, 32'd0);
        chk("c0_mem_en",    {31'd0, mem_en},    32'd1);
        chk("c0_mem_we",    {31'd0, mem_we},    32'd1);
        chk("c0_mem_addr",  {28'd0, mem_addr},  32'd0);
        chk("c0_mem_din",   {24'd0, mem_din},   32'd0);
        chk("c0_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("c0_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            chk("init_done_timing", {31'd0, init_done}, (k >= DEPTH) ? 32'd1 : 32'd0);
            chk("init_ready_timing", {31'd0, req_ready}, (k >= DEPTH) ? 32'd1 : 32'd0);
            chk("init_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            if (k < DEPTH) chk("init_addr", {28'd0, mem_addr}, k);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        #1;
        chk("wr_req_ready", {31'd0, req_ready}, 32'd1);
        chk("wr_mem_en",    {31'd0, mem_en},    32'd1);
        chk("wr_mem_we",    {31'd0, mem_we},    32'd1);
        chk("wr_mem_addr",  {28'd0, mem_addr},  {28'd0, a});
        chk("wr_mem_din",   {24'd0, mem_din},   {24'd0, d});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ref_mem[a] = d;
    endtask

    // Read with bp cycles of response backpressure; junk writes offered meanwhile must be ignored.
    task automatic rd(input logic [AW-1:0] a, input int bp);
        logic [DW-1:0] exp;
        exp = ref_mem[a];
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_wdata = 8'($urandom);
        rsp_ready = (bp == 0);
        #1;
        chk("rd_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rd_mem_en",    {31'd0, mem_en},    32'd1);
        chk("rd_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rd_mem_addr",  {28'd0, mem_addr},  {28'd0, a});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rd_n1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rd_n1_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rd_n1_mem_en",    {31'd0, mem_en},    32'd0);
        @(negedge clk);
        chk("rd_n2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_n2_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp});
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = a;
            req_wdata = ~exp;
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp});
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_mem_en",    {31'd0, mem_en},    32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rd_done_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rd_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rd_done_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp});
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        pre_en    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;

        // Values held while in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_mem_en",    {31'd0, mem_en},    32'd1);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd1);
        chk("rst_mem_addr",  {28'd0, mem_addr},  32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Dirty the SRAM (address 5 = 0xFF and others random) before the clear pass.
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            pre_en   = 1'b1;
            pre_addr = AW'(i);
            pre_data = (i == 5) ? 8'hFF : 8'($urandom);
            @(posedge clk);
            #1;
            pre_en = 1'b0;
        end

        run_init();
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), 0);

        // Directed write/read and backpressure.
        wr(4'h3, 8'hA5);
        wr(4'h7, 8'h3C);
        rd(4'h3, 0);
        rd(4'h7, 0);
        rd(4'h3, 4);

        // Back-to-back writes over the whole array, then read back.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 8'(8'h10 + i));
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), 0);

        // Read-after-write in consecutive cycles.
        wr(4'h9, 8'h6E);
        rd(4'h9, 0);

        // Idle quiet.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_mem_en",    {31'd0, mem_en},    32'd0);
            chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end

        // Randomized mix against the reference array.
        for (int n = 0; n < 80; n++) begin
            op_a = AW'($urandom);
            op_d = DW'($urandom);
            if ($urandom_range(0, 1) == 1) wr(op_a, op_d);
            else                           rd(op_a, int'($urandom_range(0, 2)));
        end

        // Reset while a read is in flight.
        wr(4'h7, 8'h5A);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'h7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_init_done", {31'd0, init_done}, 32'd0);
        chk("mid_mem_we",    {31'd0, mem_we},    32'd1);
        chk("mid_mem_addr",  {28'd0, mem_addr},  32'd0);
        chk("mid_req_ready", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        run_init();
        rd(4'h7, 0);
        rd(4'h3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
